// File: rtl/adc_seq_if.sv
// Bundle between the readout/config logic and the SAR ADC sequencer.
// master = controlling side (readout logic / ADC comparator), slave = sequencer.
interface adc_seq_if #(
    parameter int MADC = 17
);
    // Readout/config side
    logic            start;
    logic            abort;
    logic            cont;
    logic [5:0]      cfg_en;
    logic            busy;
    logic [MADC-1:0] result;
    logic            result_valid;

    // ADC macro side
    logic            comp_out;
    logic            seq_init;
    logic            seq_samp;
    logic            seq_comp;
    logic            seq_update;
    logic            en_init;
    logic            en_samp_p;
    logic            en_samp_n;
    logic            en_comp;
    logic            en_update_p;
    logic            en_update_n;

    modport master (
        output start, abort, cont, cfg_en, comp_out,
        input  busy, result, result_valid,
        input  seq_init, seq_samp, seq_comp, seq_update,
        input  en_init, en_samp_p, en_samp_n, en_comp, en_update_p, en_update_n
    );

    modport slave (
        input  start, abort, cont, cfg_en, comp_out,
        output busy, result, result_valid,
        output seq_init, seq_samp, seq_comp, seq_update,
        output en_init, en_samp_p, en_samp_n, en_comp, en_update_p, en_update_n
    );
endinterface

// File: rtl/adc_seq_ctrl.sv
// SAR ADC conversion sequencer: INIT/SAMP/COMP/CAPT/UPDATE strobes, MSB-first result.
// Optional back-to-back conversions when ADC_SEQ_CONTINUOUS_EN is defined.
module adc_seq_ctrl #(
    parameter int MADC        = 17,
    parameter int SAMP_CYCLES = 2
) (
    input logic     clk,
    input logic     rst,
    adc_seq_if.slave bus
);
    localparam int            KW        = $clog2(MADC);
    localparam logic [KW-1:0] K_LAST    = KW'(MADC - 1);
    localparam logic [7:0]    SAMP_LOAD = 8'(SAMP_CYCLES - 1);

    generate
        if (MADC < 2 || MADC > 32) begin : g_bad_madc
            $error("adc_seq_ctrl: MADC must be in 2..32");
        end
        if (SAMP_CYCLES < 1 || SAMP_CYCLES > 255) begin : g_bad_samp
            $error("adc_seq_ctrl: SAMP_CYCLES must be in 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SAMP,
        ST_COMP,
        ST_CAPT,
        ST_UPDATE
    } state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [7:0]      samp_cnt_reg, samp_cnt_next;
    logic [MADC-1:0] shift_reg, shift_next;
    logic [MADC-1:0] result_reg, result_next;
    logic            result_valid_reg, result_valid_next;
    logic [5:0]      en_reg, en_next;
    logic [3:0]      strobe_reg, strobe_next;   // {init, samp, comp, update}
    logic            busy_reg, busy_next;
    logic            last_decision;
    logic            restart;

`ifdef ADC_SEQ_CONTINUOUS_EN
    assign restart = bus.cont;
`else
    logic cont_unused;
    assign cont_unused = bus.cont;
    assign restart     = 1'b0;
`endif

    assign last_decision = (k_reg == K_LAST);

    // Each shift bit owns one decision index; INIT clears, CAPT of that index loads comp_out.
    genvar gi;
    generate
        for (gi = 0; gi < MADC; gi++) begin : g_shift
            localparam logic [KW-1:0] K_SEL = KW'(MADC - 1 - gi);
            always_comb begin
                shift_next[gi] = shift_reg[gi];
                if (state_reg == ST_INIT) begin
                    shift_next[gi] = 1'b0;
                end else if (state_reg == ST_CAPT && k_reg == K_SEL) begin
                    shift_next[gi] = bus.comp_out;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        k_next            = k_reg;
        samp_cnt_next     = samp_cnt_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;
        en_next           = en_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    en_next    = bus.cfg_en;
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                k_next        = '0;
                samp_cnt_next = SAMP_LOAD;
                state_next    = ST_SAMP;
            end
            ST_SAMP: begin
                if (samp_cnt_reg == 8'd0) begin
                    state_next = ST_COMP;
                end else begin
                    samp_cnt_next = samp_cnt_reg - 8'd1;
                end
            end
            ST_COMP: begin
                state_next = ST_CAPT;
            end
            ST_CAPT: begin
                if (!last_decision) begin
                    state_next = ST_UPDATE;
                end else begin
                    // shift_next already carries the final decision in bit 0
                    result_next       = shift_next;
                    result_valid_next = 1'b1;
                    if (restart) begin
                        en_next    = bus.cfg_en;
                        state_next = ST_INIT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_UPDATE: begin
                if (!last_decision) begin
                    k_next = k_reg + KW'(1);
                end
                state_next = ST_COMP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything except reset and leaves result/enables untouched.
        if (bus.abort) begin
            state_next        = ST_IDLE;
            result_next       = result_reg;
            result_valid_next = 1'b0;
            en_next           = en_reg;
        end
    end

    // Strobes and busy are decoded from the next state so they are flop outputs.
    always_comb begin
        strobe_next = 4'b0000;
        case (state_next)
            ST_INIT:   strobe_next = 4'b1000;
            ST_SAMP:   strobe_next = 4'b0100;
            ST_COMP:   strobe_next = 4'b0010;
            ST_UPDATE: strobe_next = 4'b0001;
            default:   strobe_next = 4'b0000;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            k_reg            <= '0;
            samp_cnt_reg     <= 8'd0;
            shift_reg        <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            en_reg           <= 6'd0;
            strobe_reg       <= 4'b0000;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            k_reg            <= k_next;
            samp_cnt_reg     <= samp_cnt_next;
            shift_reg        <= shift_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            en_reg           <= en_next;
            strobe_reg       <= strobe_next;
            busy_reg         <= busy_next;
        end
    end

    assign bus.seq_init     = strobe_reg[3];
    assign bus.seq_samp     = strobe_reg[2];
    assign bus.seq_comp     = strobe_reg[1];
    assign bus.seq_update   = strobe_reg[0];
    assign bus.busy         = busy_reg;
    assign bus.result       = result_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.en_init      = en_reg[5];
    assign bus.en_samp_p    = en_reg[4];
    assign bus.en_samp_n    = en_reg[3];
    assign bus.en_comp      = en_reg[2];
    assign bus.en_update_p  = en_reg[1];
    assign bus.en_update_n  = en_reg[0];
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: default instance (17/2) plus a MADC=2/SAMP_CYCLES=1 instance.
module tb_adc_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_seq_if #(.MADC(17)) b0 ();
    adc_seq_if #(.MADC(2))  b1 ();

    adc_seq_ctrl u0 (.clk(clk), .rst(rst), .bus(b0));
    adc_seq_ctrl #(.MADC(2), .SAMP_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct { logic [16:0] res; int at; } exp0_t;
    typedef struct { logic [1:0]  res; int at; } exp1_t;
    exp0_t q0[$];
    exp1_t q1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_init, n_samp, n_comp, n_upd, n_upd1;
    int onehot_bad = 0;
    int idx0 = 0;
    int idx1 = 0;
    logic [16:0] pat0 = '0;
    logic [1:0]  pat1 = '0;

    localparam logic [16:0] PAT_A = 17'b10110011101001101;
    localparam logic [16:0] PAT_B = 17'b01101011100101001;
    localparam logic [16:0] PAT_C = 17'b11100000111100001;
    localparam logic [16:0] PAT_D = 17'b00011001100110011;
    localparam logic [16:0] PAT_E = 17'b10000000000000001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [5:0] en0();
        return {b0.en_init, b0.en_samp_p, b0.en_samp_n, b0.en_comp, b0.en_update_p, b0.en_update_n};
    endfunction

    function automatic logic [3:0] strb0();
        return {b0.seq_init, b0.seq_samp, b0.seq_comp, b0.seq_update};
    endfunction

    // Comparator models: present the next pattern bit from the COMP cycle through CAPT.
    always @(negedge clk) begin
        if (b0.seq_init) idx0 = 0;
        if (b0.seq_comp && idx0 < 17) begin
            b0.comp_out = pat0[16 - idx0];
            idx0++;
        end
        if (b1.seq_init) idx1 = 0;
        if (b1.seq_comp && idx1 < 2) begin
            b1.comp_out = pat1[1 - idx1];
            idx1++;
        end
    end

    // Monitor: strobe statistics and scoreboard pops on result_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (b0.seq_init)   n_init++;
            if (b0.seq_samp)   n_samp++;
            if (b0.seq_comp)   n_comp++;
            if (b0.seq_update) n_upd++;
            if (b1.seq_update) n_upd1++;
            if ($countones(strb0()) > 1) onehot_bad++;
            if ($countones({b1.seq_init, b1.seq_samp, b1.seq_comp, b1.seq_update}) > 1) onehot_bad++;
        end
        if (b0.result_valid) begin
            if (q0.size() == 0) begin
                check("unexpected_valid0", 1, 0);
            end else begin
                exp0_t e;
                e = q0.pop_front();
                check("result0", b0.result, e.res);
                check("valid_cycle0", cyc, e.at);
                $display("dut0 conversion: result=%05h at cycle %0d", b0.result, cyc);
            end
        end
        if (b1.result_valid) begin
            if (q1.size() == 0) begin
                check("unexpected_valid1", 1, 0);
            end else begin
                exp1_t e;
                e = q1.pop_front();
                check("result1", b1.result, e.res);
                check("valid_cycle1", cyc, e.at);
                $display("dut1 conversion: result=%0b at cycle %0d", b1.result, cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the INIT cycle.
    task automatic start0(input logic [5:0] cfg, input logic [16:0] pat);
        pat0        = pat;
        b0.cfg_en   = cfg;
        b0.start    = 1'b1;
        q0.push_back('{pat, cyc + 1 + 53});
        @(negedge clk);
        b0.start = 1'b0;
        check("init_strobe", strb0(), 4'b1000);
        check("busy_at_init", b0.busy, 1'b1);
        check("en_latched", en0(), cfg);
    endtask

    task automatic wait_valid0(input int max, input string nm);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!b0.result_valid && i < max);
        check(nm, b0.result_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int guard;
        b0.start = 0; b0.abort = 0; b0.cont = 0; b0.cfg_en = 6'd0; b0.comp_out = 0;
        b1.start = 0; b1.abort = 0; b1.cont = 0; b1.cfg_en = 6'd0; b1.comp_out = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_strobes0", strb0(), 4'b0000);
        check("rst_busy0", b0.busy, 1'b0);
        check("rst_result0", b0.result, 17'd0);
        check("rst_valid0", b0.result_valid, 1'b0);
        check("rst_en0", en0(), 6'd0);
        check("rst_result1", b1.result, 2'd0);

        // Full conversion with the reference pattern
        @(negedge clk);
        n_init = 0; n_samp = 0; n_comp = 0; n_upd = 0;
        start0(6'b101101, PAT_A);
        wait_valid0(80, "valid_a");
        check("n_init", n_init, 1);
        check("n_samp", n_samp, 2);
        check("n_comp", n_comp, 17);
        check("n_update", n_upd, 16);
        repeat (3) @(negedge clk);
        check("result_hold", b0.result, PAT_A);
        check("idle_busy", b0.busy, 1'b0);

        // Abort during the 5th COMP
        start0(6'b010010, PAT_B);
        c = 0; guard = 0;
        while (c < 5 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (b0.seq_comp) c++;
        end
        check("abort_reached", c, 5);
        b0.abort = 1'b1;
        b0.start = 1'b1;
        q0.delete();
        @(negedge clk);
        b0.abort = 1'b0;
        b0.start = 1'b0;
        check("abort_busy", b0.busy, 1'b0);
        check("abort_strobes", strb0(), 4'b0000);
        check("abort_result", b0.result, PAT_A);
        check("abort_valid", b0.result_valid, 1'b0);
        check("abort_en", en0(), 6'b010010);
        repeat (60) @(negedge clk);
        check("abort_stays_idle", b0.busy, 1'b0);
        start0(6'b100001, PAT_B);
        wait_valid0(80, "valid_after_abort");

        // Starts and cfg changes while busy are ignored
        @(negedge clk);
        start0(6'b110011, PAT_C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b0.start  = cyc[0];
            b0.cfg_en = ~b0.cfg_en;
        end
        b0.start = 1'b0;
        check("en_stable", en0(), 6'b110011);
        wait_valid0(80, "valid_c");
        // Back-to-back start in the result_valid cycle
        start0(6'b001100, PAT_D);
        wait_valid0(80, "valid_d");

        // Reset at the 30th busy cycle
        @(negedge clk);
        start0(6'b111111, PAT_E);
        c = 1; guard = 0;
        while (c < 30 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (b0.busy) c++;
        end
        check("busy_30", c, 30);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_strobes", strb0(), 4'b0000);
        check("mid_rst_busy", b0.busy, 1'b0);
        check("mid_rst_result", b0.result, 17'd0);
        check("mid_rst_en", en0(), 6'd0);
        check("mid_rst_valid", b0.result_valid, 1'b0);

        // Small instance: MADC=2, SAMP_CYCLES=1
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            pat1      = (t == 0) ? 2'b10 : 2'b01;
            b1.cfg_en = 6'b011110;
            b1.start  = 1'b1;
            q1.push_back('{pat1, cyc + 1 + 7});
            n_upd1    = 0;
            @(negedge clk);
            b1.start = 1'b0;
            guard = 0;
            while (!b1.result_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("valid1_seen", b1.result_valid, 1'b1);
            check("n_update1", n_upd1, 1);
        end

`ifdef ADC_SEQ_CONTINUOUS_EN
        @(negedge clk);
        b0.cont = 1'b1;
        start0(6'b101010, PAT_C);
        repeat (5) @(negedge clk);
        b0.cfg_en = 6'b000111;
        wait_valid0(80, "cont_valid_1");
        check("cont_busy", b0.busy, 1'b1);
        check("cont_reinit", strb0(), 4'b1000);
        check("cont_relatch", en0(), 6'b000111);
        q0.push_back('{PAT_C, cyc + 53});
        repeat (5) @(negedge clk);
        b0.cont = 1'b0;
        wait_valid0(80, "cont_valid_2");
        @(negedge clk);
        check("cont_drop_idle", b0.busy, 1'b0);
`else
        @(negedge clk);
        b0.cont = 1'b1;
        start0(6'b101010, PAT_C);
        wait_valid0(80, "cont_ignored_valid");
        @(negedge clk);
        check("cont_ignored_idle", b0.busy, 1'b0);
        b0.cont = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("strobes_onehot", onehot_bad, 0);
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
